// File: rtl/dmem_mmio_if.sv
// dmem_mmio_if: datapath load/store bus plus transmit FIFO handshake
interface dmem_mmio_if;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    modport master (output mem_write, addr, write_data, tx_ready, input read_data, tx_data, tx_valid);
    modport slave  (input mem_write, addr, write_data, tx_ready, output read_data, tx_data, tx_valid);
endinterface

// File: rtl/dmem_mmio.sv
// dmem_mmio: single-cycle data RAM with MMIO transmit FIFO, status and cycle counter
module dmem_mmio #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input logic        clk,
    input logic        reset,
    dmem_mmio_if.slave bus
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [31:0] r_ram  [RAM_WORDS];
    logic [31:0] r_fifo [FIFO_DEPTH];
    logic [PW:0] r_wp, r_rp;
    logic        r_ovf;
    logic [31:0] r_cyc;
    logic        w_mmio, w_empty, w_full, w_push_req, w_push, w_pop, w_stat_wr, w_cyc_wr;
    logic [15:0] w_off;
    logic [AW-1:0] w_idx;
    logic [PW:0] w_count;
    logic [31:0] w_status;
    assign w_mmio     = bus.addr[31:16] == 16'hFFFF;
    assign w_off      = bus.addr[15:0];
    assign w_idx      = bus.addr[AW+1:2];
    assign w_count    = r_wp - r_rp;
    assign w_empty    = r_wp == r_rp;
    assign w_full     = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
    assign w_push_req = bus.mem_write && w_mmio && w_off == 16'h0;
    assign w_stat_wr  = bus.mem_write && w_mmio && w_off == 16'h4;
    assign w_cyc_wr   = bus.mem_write && w_mmio && w_off == 16'h8;
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = !w_empty && bus.tx_ready;
    assign w_status   = {16'h0, 8'(w_count), 5'h0, r_ovf, w_full, w_empty};
    assign bus.read_data = !w_mmio ? r_ram[w_idx] :
                           w_off == 16'h4 ? w_status :
                           w_off == 16'h8 ? r_cyc : 32'h0;
    assign bus.tx_valid = !w_empty;
    assign bus.tx_data  = r_fifo[r_rp[PW-1:0]];
    // Storage arrays: RAM on RAM-selected stores, FIFO slot on accepted pushes; neither is reset
    always_ff @(posedge clk) begin
        if (bus.mem_write && !w_mmio) r_ram[w_idx] <= bus.write_data;
        if (w_push) r_fifo[r_wp[PW-1:0]] <= bus.write_data;
    end
    // Control state: FIFO pointers, sticky overflow (set beats clear), loadable cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_ovf <= 1'b0;
            r_cyc <= '0;
        end else begin
            r_wp  <= r_wp + (PW+1)'(w_push);
            r_rp  <= r_rp + (PW+1)'(w_pop);
            r_ovf <= (w_push_req && w_full) ? 1'b1 : w_stat_wr ? 1'b0 : r_ovf;
            r_cyc <= w_cyc_wr ? bus.write_data : r_cyc + 32'd1;
        end
    end
endmodule
